// File: rtl/move_scheduler.sv
// Queues keyboard pulses and issues them one at a time to the 2048 engine over valid/ready.
// Define VBLANK_SYNC_EN to hold each issue until vertical blanking; otherwise vblank is ignored.
module move_scheduler #(
    parameter int DEPTH   = 4,
    parameter int TIMEOUT = 1024
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic                     up,
    input  logic                     down,
    input  logic                     left,
    input  logic                     right,
    input  logic                     Enter,
    input  logic                     vblank,
    input  logic                     win,
    input  logic                     GG,
    input  logic                     game_busy,
    input  logic                     cmd_ready,
    output logic                     cmd_valid,
    output logic [2:0]               cmd_code,
    output logic [$clog2(DEPTH):0]   fifo_count,
    output logic                     overflow,
    output logic                     timeout,
    output logic                     locked
);
    localparam int AW = $clog2(DEPTH);
    localparam int CW = $clog2(TIMEOUT);
    localparam logic [AW:0]   FULL    = (AW+1)'(DEPTH);
    localparam logic [CW-1:0] CNT_MAX = CW'(TIMEOUT - 1);

    typedef enum logic [1:0] {IDLE, WAIT_VBLANK, ISSUE, WAIT_DONE} state_t;

    state_t          state_q;
    logic [2:0]      mem_q [DEPTH];
    logic [AW-1:0]   wr_ptr_q, rd_ptr_q, wr_ptr_d, rd_ptr_d, wr_base, rd_base;
    logic [AW:0]     count_q, count_d, count_base;
    logic [CW-1:0]   cnt_q;
    logic [2:0]      head_q, cmd_code_q, key_code;
    logic            cmd_valid_q, overflow_q, timeout_q, locked_q;
    logic            lock_now, lock_any, lock_rise, vblank_ok;
    logic            push_req, push_ok, pop, ovf_set, enter_hs;

`ifdef VBLANK_SYNC_EN
    assign vblank_ok = vblank;
`else
    logic unused_vblank;
    assign unused_vblank = vblank;
    assign vblank_ok     = 1'b1;
`endif

    always_comb begin
        lock_now  = win | GG;
        lock_any  = lock_now | locked_q;
        lock_rise = lock_now & ~locked_q;

        key_code = '0;
        if (!lock_any && up)         key_code = 3'd1;
        else if (!lock_any && down)  key_code = 3'd2;
        else if (!lock_any && left)  key_code = 3'd3;
        else if (!lock_any && right) key_code = 3'd4;
        else if (Enter)              key_code = 3'd5;
        push_req = (key_code != '0);

        // A flush on the lock edge happens first; a surviving pulse is then written into the emptied FIFO.
        count_base = lock_rise ? '0 : count_q;
        wr_base    = lock_rise ? '0 : wr_ptr_q;
        rd_base    = lock_rise ? '0 : rd_ptr_q;
        pop        = (state_q == WAIT_VBLANK) && vblank_ok && !lock_rise && (count_q != '0);
        push_ok    = push_req && ((count_base != FULL) || pop);
        ovf_set    = push_req && !push_ok;

        wr_ptr_d = wr_base + AW'(push_ok);
        rd_ptr_d = rd_base + AW'(pop);
        count_d  = count_base + (AW+1)'(push_ok) - (AW+1)'(pop);

        enter_hs = (state_q == ISSUE) && cmd_valid_q && cmd_ready && (cmd_code_q == 3'd5);
    end

    always_ff @(posedge clk) begin
        if (push_ok) mem_q[wr_base] <= key_code;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q     <= IDLE;
            wr_ptr_q    <= '0;
            rd_ptr_q    <= '0;
            count_q     <= '0;
            cnt_q       <= '0;
            head_q      <= '0;
            cmd_code_q  <= '0;
            cmd_valid_q <= 1'b0;
            overflow_q  <= 1'b0;
            timeout_q   <= 1'b0;
            locked_q    <= 1'b0;
        end else begin
            locked_q <= lock_now;
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            count_q  <= count_d;

            if (ovf_set)       overflow_q <= 1'b1;
            else if (enter_hs) overflow_q <= 1'b0;
            if (enter_hs)      timeout_q  <= 1'b0;

            case (state_q)
                IDLE: begin
                    if (count_q != '0) state_q <= WAIT_VBLANK;
                end
                WAIT_VBLANK: begin
                    if (count_q == '0 || lock_rise) begin
                        state_q <= IDLE;
                    end else if (vblank_ok) begin
                        state_q <= ISSUE;
                        head_q  <= mem_q[rd_ptr_q];
                    end
                end
                ISSUE: begin
                    if (!cmd_valid_q) begin
                        cmd_valid_q <= 1'b1;
                        cmd_code_q  <= head_q;
                    end else if (cmd_ready) begin
                        cmd_valid_q <= 1'b0;
                        cmd_code_q  <= '0;
                        cnt_q       <= '0;
                        state_q     <= WAIT_DONE;
                    end
                end
                WAIT_DONE: begin
                    if (!game_busy) begin
                        state_q <= IDLE;
                    end else if (cnt_q == CNT_MAX) begin
                        state_q   <= IDLE;
                        timeout_q <= 1'b1;
                    end else begin
                        cnt_q <= cnt_q + CW'(1);
                    end
                end
                default: state_q <= IDLE;
            endcase
        end
    end

    assign cmd_valid  = cmd_valid_q;
    assign cmd_code   = cmd_code_q;
    assign fifo_count = count_q;
    assign overflow   = overflow_q;
    assign timeout    = timeout_q;
    assign locked     = locked_q;
endmodule

// File: tb/tb_move_scheduler.sv
// Directed bench for move_scheduler; expected values are hand-derived from the cycle-level behaviour.
module tb_move_scheduler;
    localparam int TO = 16;
    localparam logic [4:0] K_UP = 5'b10000, K_DOWN = 5'b01000, K_LEFT = 5'b00100,
                           K_RIGHT = 5'b00010, K_ENTER = 5'b00001;

    logic clk = 1'b0;
    logic rst, up, down, left, right, Enter, vblank, win, GG, game_busy, cmd_ready;
    logic       cmd_valid, overflow, timeout, locked;
    logic [2:0] cmd_code;
    logic [2:0] fifo_count;
    int n_tests = 0;
    int n_fail  = 0;

    move_scheduler #(.DEPTH(4), .TIMEOUT(TO)) dut (
        .clk(clk), .rst(rst), .up(up), .down(down), .left(left), .right(right),
        .Enter(Enter), .vblank(vblank), .win(win), .GG(GG), .game_busy(game_busy),
        .cmd_ready(cmd_ready), .cmd_valid(cmd_valid), .cmd_code(cmd_code),
        .fifo_count(fifo_count), .overflow(overflow), .timeout(timeout), .locked(locked)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0d expected %0d", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic ticks(input int n);
        for (int i = 0; i < n; i++) tick();
    endtask

    task automatic pulse(input logic [4:0] k);
        {up, down, left, right, Enter} = k;
        tick();
        {up, down, left, right, Enter} = '0;
    endtask

    // Waits (bounded) for an offered command, checks its code, then lets one edge pass for the handshake.
    task automatic expect_issue(input string tag, input int code);
        int n = 0;
        while (!cmd_valid && n < 20) begin
            tick();
            n++;
        end
        check({tag, "_vld"}, cmd_valid, 1);
        check({tag, "_code"}, cmd_code, code);
        tick();
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: got no finish expected finish");
        $fatal(1, "watchdog");
    end

    initial begin
        rst = 1'b1; {up, down, left, right, Enter} = '0;
        vblank = 1'b1; win = 1'b0; GG = 1'b0; game_busy = 1'b0; cmd_ready = 1'b1;
        ticks(3);
        check("rst_vld", cmd_valid, 0);
        check("rst_code", cmd_code, 0);
        check("rst_cnt", fifo_count, 0);
        check("rst_flags", {overflow, timeout, locked}, 0);
        rst = 1'b0;
        ticks(6);

        // Latency: pulse sampled at edge N, valid appears after edge N+3 for one cycle
        pulse(K_UP);
        check("lat_cnt_n", fifo_count, 1);
        tick();
        check("lat_vld_n1", cmd_valid, 0);
        tick();
        check("lat_vld_n2", cmd_valid, 0);
        check("lat_cnt_n2", fifo_count, 0);
        tick();
        check("lat_vld_n3", cmd_valid, 1);
        check("lat_code_n3", cmd_code, 1);
        tick();
        check("lat_vld_n4", cmd_valid, 0);
        check("lat_code_n4", cmd_code, 0);
        ticks(4);

        // Priority: up and left together enqueue only up
        pulse(K_UP | K_LEFT);
        check("pri_cnt", fifo_count, 1);
        expect_issue("pri", 1);
        ticks(8);
        check("pri_idle_vld", cmd_valid, 0);
        check("pri_cnt_end", fifo_count, 0);
        check("pri_ovf", overflow, 0);

        // Overflow: one held in the cmd register, four queued, sixth dropped
        cmd_ready = 1'b0;
        pulse(K_UP);
        ticks(3);
        check("ovf_held_vld", cmd_valid, 1);
        check("ovf_held_code", cmd_code, 1);
        pulse(K_DOWN);
        pulse(K_LEFT);
        pulse(K_RIGHT);
        pulse(K_UP);
        check("ovf_cnt_full", fifo_count, 4);
        check("ovf_not_yet", overflow, 0);
        pulse(K_DOWN);
        check("ovf_cnt_stay", fifo_count, 4);
        check("ovf_set", overflow, 1);
        check("ovf_held_stable", cmd_code, 1);
        cmd_ready = 1'b1;
        expect_issue("ovf_i0", 1);
        expect_issue("ovf_i1", 2);
        expect_issue("ovf_i2", 3);
        expect_issue("ovf_i3", 4);
        expect_issue("ovf_i4", 1);
        ticks(10);
        check("ovf_drained_vld", cmd_valid, 0);
        check("ovf_drained_cnt", fifo_count, 0);
        check("ovf_sticky", overflow, 1);

        // Vblank gating
        vblank = 1'b0;
        pulse(K_UP);
        pulse(K_DOWN);
`ifdef VBLANK_SYNC_EN
        ticks(8);
        check("vb_hold_vld", cmd_valid, 0);
        check("vb_hold_cnt", fifo_count, 2);
        vblank = 1'b1;
        expect_issue("vb_i0", 1);
        expect_issue("vb_i1", 2);
`else
        expect_issue("vb_i0", 1);
        expect_issue("vb_i1", 2);
        vblank = 1'b1;
`endif
        ticks(6);

        // Timeout: engine stays busy after accept
        game_busy = 1'b1;
        pulse(K_LEFT);
        expect_issue("to_issue", 3);
        check("to_vld_off", cmd_valid, 0);
        ticks(TO - 1);
        check("to_before", timeout, 0);
        tick();
        check("to_set", timeout, 1);
        game_busy = 1'b0;
        ticks(4);

        // Lock: GG flushes queue, directions ignored, Enter clears stickies
        cmd_ready = 1'b0;
        pulse(K_UP);
        ticks(3);
        check("lk_held_vld", cmd_valid, 1);
        pulse(K_DOWN);
        pulse(K_LEFT);
        pulse(K_RIGHT);
        check("lk_cnt3", fifo_count, 3);
        GG = 1'b1;
        tick();
        check("lk_flush", fifo_count, 0);
        check("lk_locked", locked, 1);
        check("lk_no_retract", {cmd_valid, cmd_code}, {1'b1, 3'd1});
        pulse(K_RIGHT);
        check("lk_dir_ign", fifo_count, 0);
        pulse(K_ENTER);
        check("lk_enter_q", fifo_count, 1);
        check("lk_stickies", {overflow, timeout}, 2'b11);
        cmd_ready = 1'b1;
        expect_issue("lk_i0", 1);
        check("lk_ovf_keep", overflow, 1);
        expect_issue("lk_enter", 5);
        check("lk_ovf_clr", overflow, 0);
        check("lk_to_clr", timeout, 0);
        GG = 1'b0;
        ticks(2);
        check("lk_unlocked", locked, 0);
        ticks(4);

        // Reset in the middle of ISSUE drops the pending command
        cmd_ready = 1'b0;
        pulse(K_RIGHT);
        ticks(3);
        check("mr_vld", cmd_valid, 1);
        pulse(K_DOWN);
        win = 1'b1;
        rst = 1'b1;
        tick();
        check("mr_vld_off", cmd_valid, 0);
        check("mr_code", cmd_code, 0);
        check("mr_cnt", fifo_count, 0);
        check("mr_flags", {overflow, timeout, locked}, 0);
        rst = 1'b0;
        win = 1'b0;
        cmd_ready = 1'b1;
        ticks(8);
        check("mr_quiet", cmd_valid, 0);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end
endmodule

// File: doc/move_scheduler.md
Name: move_scheduler

Overview:
Sequences player commands into the 2048 game engine. Captures one-cycle key pulses from the keyboard decoder in a small FIFO and issues them one at a time over a valid/ready handshake. Waits for the engine to finish each move, and optionally aligns issue to VGA vertical blanking so board updates never tear mid-frame. Sits between the keyboard decoder and the game-state block; win/GG feedback from the game state locks out moves.

Parameters:
DEPTH, 4, FIFO entries; power of 2, minimum 2.
TIMEOUT, 1024, maximum cycles spent in WAIT_DONE before forced return to IDLE.

Ports:
clk  input  1  system clock
rst  input  1  synchronous reset, active-high
up  input  1  one-cycle key pulse
down  input  1  one-cycle key pulse
left  input  1  one-cycle key pulse
right  input  1  one-cycle key pulse
Enter  input  1  one-cycle key pulse
vblank  input  1  level, high during vertical blanking; already in the clk domain
win  input  1  level from game state
GG  input  1  level from game state
game_busy  input  1  level, high while the engine applies a move
cmd_ready  input  1  engine accepts cmd
cmd_valid  output  1  command offered
cmd_code  output  3  1=up 2=down 3=left 4=right 5=Enter; 0 when cmd_valid=0
fifo_count  output  clog2(DEPTH)+1  entries queued
overflow  output  1  sticky: a pulse was dropped because the FIFO was full
timeout  output  1  sticky: a WAIT_DONE timeout occurred
locked  output  1  registered win|GG

Behaviour:
- Reset: state IDLE, FIFO empty, cmd_valid=0, cmd_code=0, fifo_count=0, overflow=0, timeout=0, locked=0, timeout counter=0. Reset mid-handshake drops the pending command.
- Enqueue: if several pulses arrive in one cycle, only the highest priority is written: up > down > left > right > Enter. The others are discarded and do not set overflow.
- Lock: locked <= win|GG every cycle.
  - When locked=1, direction pulses are discarded; only Enter is enqueued.
  - On the rising edge of locked, the FIFO is flushed in the same cycle. A pulse in that cycle is evaluated under the lock rule and may be written after the flush.
- FIFO full:
  - Enqueue with no pop in the same cycle: drop the pulse, set overflow.
  - Simultaneous push and pop when full: both happen, count unchanged.
  - Pop on empty never occurs.
  - Pointers wrap modulo DEPTH.
- Clearing stickies: overflow and timeout clear only on rst or on an accepted Enter handshake.
- FSM:
  - IDLE: fifo_count>0 -> WAIT_VBLANK.
  - WAIT_VBLANK: vblank=1 -> ISSUE. The FIFO head is popped into the cmd register on this transition, and cmd_valid=1 from the next cycle.
  - ISSUE:
    - cmd_valid and cmd_code are held stable until cmd_valid&cmd_ready.
    - On handshake, cmd_valid=0 next cycle -> WAIT_DONE, counter cleared.
    - A lock rising edge during ISSUE does not retract the command.
  - WAIT_DONE:
    - Minimum 1 cycle in this state.
    - Then game_busy=0 -> IDLE.
    - Counter increments each cycle; reaching TIMEOUT-1 with game_busy still 1 -> IDLE and sets timeout.
- Latency: a pulse at cycle N, with IDLE, empty FIFO and vblank=1, gives cmd_valid=1 at cycle N+3. That is: write N, WAIT_VBLANK N+1, ISSUE N+2, registered valid N+3.
- Throughput: at most one command in flight; a new issue starts no earlier than 1 cycle after WAIT_DONE exits.
- If vblank drops while in ISSUE, the command stays offered; vblank is sampled only in WAIT_VBLANK.

Optional Feature:
VBLANK_SYNC_EN:
- Defined: WAIT_VBLANK waits for vblank=1 as above.
- Undefined: WAIT_VBLANK always proceeds to ISSUE the next cycle, and the vblank port is ignored. Idle-case latency is unchanged at N+3.

Test Plan:
- Single up pulse at cycle 10, vblank=1, cmd_ready=1, game_busy low -> cmd_valid=1, cmd_code=1 at cycle 13 for exactly one cycle; fifo_count returns to 0.
- up and left pulsed in the same cycle -> only code 1 issued; fifo_count peaks at 1; overflow stays 0.
- DEPTH=4, cmd_ready=0, six direction pulses -> fifo_count=4 (one entry held in the cmd register), overflow=1. The five accepted codes then issue in order after cmd_ready=1.
- vblank=0 with 2 queued moves -> cmd_valid stays 0 (macro defined). vblank=1 -> issue proceeds. With the macro undefined, issue happens regardless of vblank.
- GG rises with 3 queued moves -> FIFO flushed to 0, right pulse ignored, Enter pulse issues code 5; overflow and timeout cleared on that handshake.
- game_busy held high after accept -> return to IDLE after TIMEOUT cycles with timeout=1. A rst mid-ISSUE gives cmd_valid=0 on the next cycle and all outputs at their reset values.
